// File: rtl/divider_64b_seq.sv
// divider_64b_seq: iterative radix-2 restoring divider (DIV/DIVU/REM/REMU), Size+2 cycle latency.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the DIV phase.
`default_nettype none

module divider_64b_seq #(
  parameter int Size = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            signed_op,
  input  logic [Size-1:0] a,
  input  logic [Size-1:0] b,
  output logic [Size-1:0] q,
  output logic [Size-1:0] r,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(Size + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [Size:0]   r_rem;
  logic [Size-1:0] r_dq;
  logic [Size-1:0] r_b_abs;
  logic [Size-1:0] r_a;
  logic            r_neg_a;
  logic            r_neg_b;
  logic            r_zero;

  logic            w_neg_a;
  logic            w_neg_b;
  logic [Size-1:0] w_a_abs;
  logic [Size-1:0] w_b_abs;
  logic [Size:0]   w_rem_sh;
  logic [Size+1:0] w_trial;
  logic [Size-1:0] w_q_fix;
  logic [Size-1:0] w_r_fix;

  assign w_neg_a = signed_op & a[Size-1];
  assign w_neg_b = signed_op & b[Size-1];
  // Negating the most negative value wraps back to 2^(Size-1), which is the wanted magnitude.
  assign w_a_abs = w_neg_a ? (~a + 1'b1) : a;
  assign w_b_abs = w_neg_b ? (~b + 1'b1) : b;

  // Bring the next dividend bit into the partial remainder; sign of the trial decides the quotient bit.
  assign w_rem_sh = (r_rem << 1) | {{Size{1'b0}}, r_dq[Size-1]};
  assign w_trial  = {1'b0, w_rem_sh} - {2'b00, r_b_abs};

  assign w_q_fix = (r_neg_a ^ r_neg_b) ? (~r_dq + 1'b1) : r_dq;
  assign w_r_fix = r_neg_a ? (~r_rem[Size-1:0] + 1'b1) : r_rem[Size-1:0];

`ifdef DIV_EARLY_OUT_EN
  logic w_early;
  // With dq preloaded with |a| and rem cleared, FIX already yields the overflow result directly.
  assign w_early = (b == '0) |
                   (signed_op & (a == {1'b1, {(Size-1){1'b0}}}) & (b == '1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_dq    <= '0;
      r_b_abs <= '0;
      r_a     <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_zero  <= 1'b0;
      q       <= '0;
      r       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            r_b_abs <= w_b_abs;
            r_a     <= a;
            r_zero  <= (b == '0);
            r_rem   <= '0;
            r_dq    <= w_a_abs;
            r_cnt   <= CW'(Size);
            busy    <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
            r_state <= w_early ? S_FIX : S_DIV;
`else
            r_state <= S_DIV;
`endif
          end
        end
        S_DIV: begin
          r_rem <= w_trial[Size+1] ? w_rem_sh : w_trial[Size:0];
          r_dq  <= {r_dq[Size-2:0], ~w_trial[Size+1]};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (r_zero) begin
            q <= '1;
            r <= r_a;
          end else begin
            q <= w_q_fix;
            r <= w_r_fix;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_divider_64b_seq.sv
// tb_divider_64b_seq: directed vectors with a queue scoreboard checked by a done-driven monitor.
`default_nettype none

module tb_divider_64b_seq;

  localparam int W = 64;
  localparam logic [W-1:0] MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         signed_op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;

  divider_64b_seq #(.Size(W)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .a(a), .b(b), .q(q), .r(r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int unsigned  at;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned lat(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef DIV_EARLY_OUT_EN
    if (y == '0 || (s && x == MIN && y == ONES)) return 2;
`endif
    return W + 2;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no result pending (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("q", q, e.q);
        chk("r", r, e.r);
        chk("done_cycle", W'(cyc), W'(e.at));
      end
    end
  end

  // Drives start for one cycle; cycle 0 of the operation is the cycle whose counter is n.
  task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eq, input logic [W-1:0] er, output int unsigned n);
    exp_t e;
    @(negedge clk);
    n = cyc;
    start = 1'b1;
    signed_op = s;
    a = x;
    b = y;
    e.q = eq;
    e.r = er;
    e.at = cyc + lat(s, x, y);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d results pending want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    int unsigned n2;

    repeat (2) @(negedge clk);
    chk("reset_q", q, '0);
    chk("reset_r", r, '0);
    chk("reset_busy", W'(busy), '0);
    chk("reset_done", W'(done), '0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", W'(busy), '0);

    // 100 / 7 unsigned with busy window checks
    issue(1'b0, 64'd100, 64'd7, 64'd14, 64'd2, n);
    chk("busy_c1", W'(busy), 1);
    wait_cyc(n + 65);
    chk("busy_c65", W'(busy), 1);
    @(negedge clk);
    chk("busy_c66", W'(busy), 0);
    drain();

    issue(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, ONES, n);
    drain();
    issue(1'b0, ONES, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, n);
    drain();
    issue(1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, ONES, 64'hFFFF_FFFF_FFFF_FFFB, n);
    drain();
    issue(1'b1, MIN, ONES, MIN, 64'd0, n);
    drain();
    issue(1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, n);
    drain();
    issue(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ONES, n);
    drain();
    issue(1'b0, 64'd5, 64'd0, ONES, 64'd5, n);
    drain();
    issue(1'b0, ONES, ONES, 64'd1, 64'd0, n);
    drain();

    // start while busy is ignored; start in the done cycle is accepted
    issue(1'b0, 64'd1000, 64'd3, 64'd333, 64'd1, n);
    wait_cyc(n + 20);
    start = 1'b1;
    a = 64'd9;
    b = 64'd3;
    @(negedge clk);
    start = 1'b0;
    chk("busy_ignored_start", W'(busy), 1);
    wait_cyc(n + 65);
    issue(1'b0, 64'd50, 64'd7, 64'd7, 64'd1, n2);
    chk("b2b_start_cycle", W'(n2), W'(n + 66));
    drain();

    // asynchronous reset mid-operation
    @(negedge clk);
    n = cyc;
    start = 1'b1;
    signed_op = 1'b0;
    a = 64'd12345;
    b = 64'd10;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(n + 30);
    reset = 1'b1;
    #1;
    chk("abort_busy", W'(busy), 0);
    chk("abort_done", W'(done), 0);
    chk("abort_q", q, '0);
    chk("abort_r", r, '0);
    @(negedge clk);
    reset = 1'b0;
    issue(1'b0, 64'd81, 64'd9, 64'd9, 64'd0, n);
    drain();
    repeat (3) @(negedge clk);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
